// File: rtl/kem_instruction_sequencer.sv
// Program sequencer for the Saber compute core: fetches stored command words and issues them.
// Optional WAIT watchdog compiled in with `define SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | program memory read of pc
// LOAD  | capture read data and decode
// ISSUE | captured word on the command port for one cycle
// WAIT  | launch outstanding, waiting for core_done
// HALT  | program ended (done), error if it ran off the end
module kem_instruction_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int INS_W     = 37,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ins_en,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic [INS_W-1:0]  ins_data,
  output logic [34:0]       command_in,
  output logic              command_we0,
  output logic              command_we1,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [34:0]       cmd_q;
  logic              we0_q, we1_q;
  logic              is_launch_q, is_halt_q, wrap_q;
  logic              busy_q, done_q, error_q;
  logic              set_err;
  logic              timeout;
  logic              dec_launch, dec_halt;

  assign dec_launch = ins_data[35] && (ins_data[4:0] != 5'd0);
  assign dec_halt   = !ins_data[35] && !ins_data[36] && (ins_data[4:0] == 5'd31);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  // Counter reaches all-ones on the cycle it would increment from this value.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_ISSUE) begin
      to_cnt <= '0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

  assign timeout = (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (is_halt_q) begin
          state_nxt = S_HALT;
        end else if (wrap_q) begin
          state_nxt = S_HALT;
          set_err   = 1'b1;
        end else if (is_launch_q) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_FETCH;
        end else if (timeout) begin
          state_nxt = S_HALT;
          set_err   = 1'b1;
        end
      end
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      cmd_q       <= '0;
      we0_q       <= 1'b0;
      we1_q       <= 1'b0;
      is_launch_q <= 1'b0;
      is_halt_q   <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      done_q <= (state_nxt == S_HALT);
      if (((state == S_IDLE) || (state == S_HALT)) && start) begin
        pc_q    <= '0;
        error_q <= 1'b0;
      end
      if (set_err) error_q <= 1'b1;
      if (state == S_LOAD) begin
        cmd_q       <= ins_data[34:0];
        we0_q       <= ins_data[35];
        we1_q       <= ins_data[36];
        is_launch_q <= dec_launch;
        is_halt_q   <= dec_halt;
        // pc saturates at the top; ISSUE turns that into an error halt.
        wrap_q      <= (pc_q == PC_MAX);
        if (pc_q != PC_MAX) pc_q <= pc_q + PC_ONE;
      end
    end
  end

  assign ins_en      = (state == S_FETCH);
  assign ins_addr    = ins_en ? pc_q : '0;
  assign command_in  = cmd_q;
  assign command_we0 = (state == S_ISSUE) && we0_q;
  assign command_we1 = (state == S_ISSUE) && we1_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign pc          = pc_q;

endmodule

// File: doc/kem_instruction_sequencer.md
# kem_instruction_sequencer

Program sequencer for the Saber compute core. It fetches 37-bit instruction words `{command_we1, command_we0, command_in[34:0]}` from a synchronous-read program memory and issues each word to the core's command port for one cycle. After every launch word it stalls until the core reports completion, and it stops on the halt word. It sits directly upstream of the compute core and replaces bench-driven command streams with a stored KEM program (keygen, encaps or decaps).

## Interface
Parameters:
- `ADDR_W`, default 10: program memory address width; depth is 2^ADDR_W words.
- `INS_W`, default 37: instruction width. Fixed as we1 (bit 36), we0 (bit 35), command_in (bits 34:0).
- `TIMEOUT_W`, default 20: width of the watchdog counter (used only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin execution at address 0. Sampled only in IDLE or HALT.
- `ins_en` out 1: program memory read enable.
- `ins_addr` out ADDR_W: program memory address.
- `ins_data` in INS_W: read data, valid one cycle after `ins_en`.
- `command_in` out 35: command word to the core.
- `command_we0` out 1: opcode/address write strobe to the core.
- `command_we1` out 1: length write strobe to the core.
- `core_done` in 1: core completion pulse or level.
- `busy` out 1: high in every state except IDLE and HALT.
- `done` out 1: high in HALT.
- `error` out 1: abnormal termination, sticky until `start` or `rst`.
- `pc` out ADDR_W: address of the next word to fetch.

## Operation
- Decode of the captured word w:
  - we0=1 and w[4:0]≠0: LAUNCH.
  - we0=0, we1=0 and w[4:0]=31: HALT word.
  - Any other word: PLAIN.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, HALT.
- IDLE: on `start`, pc←0 and go to FETCH.
- FETCH: `ins_en`=1 and `ins_addr`=pc, both combinational. Go to LOAD.
- LOAD: capture `ins_data` into the command registers and the decode flags. pc←pc+1. Go to ISSUE.
- ISSUE: drive the captured word for exactly one cycle. Next state by decode:
  - HALT word: go to HALT.
  - LAUNCH: go to WAIT.
  - PLAIN: go to FETCH.
- WAIT: strobes are 0. When `core_done`=1 is sampled, go to FETCH. A `core_done` seen during ISSUE is ignored.
- HALT: `done`=1. `start` clears `error` and `done` and goes to FETCH with pc=0.
- Wrap-around: if pc would increment from 2^ADDR_W−1 and the captured word is not a HALT word, the word is still issued. The sequencer then enters HALT with `error`=1. pc stays at 2^ADDR_W−1.
- Outside ISSUE:
  - `command_we0` and `command_we1` are 0.
  - `command_in` holds its last issued value, so the core sees stable operands.
- `start` while `busy` is ignored.
- `rst` in any state: go to IDLE and discard any in-flight fetch.

## Timing
- Reset values: `command_in`=0, `command_we0`=0, `command_we1`=0, `ins_en`=0, `ins_addr`=0, `pc`=0, `busy`=0, `done`=0, `error`=0. State is IDLE.
- `start` high at edge t. FETCH during cycle t+1, LOAD during t+2, first word on the command port during t+3.
- PLAIN throughput: one word every 3 cycles.
- LAUNCH: if `core_done` is sampled at edge d, the next FETCH occupies cycle d+1.
- HALT word: it is itself issued to the core in ISSUE. `done` rises the cycle after ISSUE.
- `busy` is registered and matches the state.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - On reaching all-ones without `core_done`, go to HALT with `error`=1.
- `SEQ_TIMEOUT_EN` not defined:
  - WAIT is unbounded and the counter logic is absent.
  - `error` is set only by address wrap-around.

## Test plan
- Program [we0=1 {0,0,0,op0}; halt word 31]. Pulse `start`. Required response:
  - The two words are issued at cycles t+3 and t+6.
  - `done`=1 from t+7.
  - `command_we0` is high only at t+3.
  - No WAIT state is entered.
- Launch {dest 200, src2 668, src1 200, op 6} with `core_done` pulsed 50 cycles after ISSUE. Required response:
  - `command_in`={10'd200,10'd668,10'd200,5'd6} with we0=1 for one cycle.
  - The next FETCH occurs exactly one cycle after the `core_done` pulse.
- Length word we1=1 {3'd0,16'd3744,16'd32}, then launch op 3, then halt. Required response:
  - The length word is issued with no wait.
  - The launch stalls until `core_done`.
  - The sequence ends with `done`=1.
- Program filling all 1024 words with no halt word. Required response:
  - Word 1023 is issued.
  - The sequencer then enters HALT with `error`=1 and `pc`=1023.
- Assert `rst` during WAIT, then pulse `start`. Required response:
  - All outputs return to their reset values the cycle after `rst`.
  - Execution restarts at address 0.
- With `SEQ_TIMEOUT_EN` and TIMEOUT_W=4: launch with `core_done` held low. Required response: HALT with `error`=1 after 15 WAIT cycles.
